ili_spi_tx: RTL and testbench

Serial transmitter for the ILI display link, directly downstream of the frequency divider. It takes one command or data byte per handshake and shifts it out MSB-first in SPI mode 0, with a separate D/C line. Bit timing comes from the divider's `clk_out`, which drives the `tick_src` input. The block edge-detects that signal in the `clk` domain; it is never used as a clock.

---
 rtl/ili_spi_tx.sv | 123 ++++++++++++
 tb/tb_ili_spi_tx.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ili_spi_tx.sv
// SPI mode-0 byte transmitter for the ILI display link.
// Bit timing comes from rising edges of tick_src, detected in the clk domain.
module ili_spi_tx #(
  parameter int DATA_W     = 8,
  parameter int IDLE_TICKS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_src,
  input  logic              in_valid,
  input  logic              in_dc,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              spi_cs_n,
  output logic              spi_sck,
  output logic              spi_mosi,
  output logic              spi_dc,
  output logic              done
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GW = (IDLE_TICKS > 1) ? $clog2(IDLE_TICKS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_GAP} state_t;

  state_t            state_q, state_d;
  logic              tick_q, tick;
  logic [DATA_W-1:0] sr_q, sr_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]     gap_cnt_q, gap_cnt_d;
  logic              ready_d, cs_n_d, sck_d, mosi_d, dc_d, done_d;

  assign tick = tick_src & ~tick_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      tick_q    <= 1'b0;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      in_ready  <= 1'b1;
      spi_cs_n  <= 1'b1;
      spi_sck   <= 1'b0;
      spi_mosi  <= 1'b0;
      spi_dc    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_src;
      sr_q      <= sr_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      in_ready  <= ready_d;
      spi_cs_n  <= cs_n_d;
      spi_sck   <= sck_d;
      spi_mosi  <= mosi_d;
      spi_dc    <= dc_d;
      done      <= done_d;
    end
  end

  // Outputs are computed one cycle ahead so every pin comes straight from a flop.
  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
    ready_d   = in_ready;
    cs_n_d    = spi_cs_n;
    sck_d     = spi_sck;
    mosi_d    = spi_mosi;
    dc_d      = spi_dc;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          sr_d      = in_data;
          dc_d      = in_dc;
          bit_cnt_d = BW'(DATA_W - 1);
          mosi_d    = in_data[DATA_W-1];
          cs_n_d    = 1'b0;
          ready_d   = 1'b0;
          state_d   = S_LOW;
        end
      end
      S_LOW: begin
        if (tick) begin
          sck_d   = 1'b1;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (tick) begin
          sck_d = 1'b0;
          if (bit_cnt_q == '0) begin
            cs_n_d    = 1'b1;
            done_d    = 1'b1;
            gap_cnt_d = GW'(IDLE_TICKS - 1);
            state_d   = S_GAP;
          end else begin
            sr_d      = sr_q << 1;
            mosi_d    = sr_q[DATA_W-2];
            bit_cnt_d = bit_cnt_q - BW'(1);
            state_d   = S_LOW;
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (gap_cnt_q == '0) begin
            ready_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q - GW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_ili_spi_tx.sv
// Randomized bench for ili_spi_tx: a frame-level monitor rebuilds each byte from
// the SPI pins and compares it, plus tick positions, against a queue of accepted frames.
module tb_ili_spi_tx;
  localparam int DATA_W = 8;
  localparam int IDLE_TICKS = 2;

  logic clk = 1'b0, rst = 1'b0, tick_src = 1'b0;
  logic in_valid = 1'b0, in_dc = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic in_ready, spi_cs_n, spi_sck, spi_mosi, spi_dc, done;

  ili_spi_tx #(.DATA_W(DATA_W), .IDLE_TICKS(IDLE_TICKS)) dut (
    .clk(clk), .rst(rst), .tick_src(tick_src), .in_valid(in_valid), .in_dc(in_dc),
    .in_data(in_data), .in_ready(in_ready), .spi_cs_n(spi_cs_n), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_dc(spi_dc), .done(done)
  );

  int errors = 0, checks = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  always #5 clk = ~clk;

  // Divider model: tick_src toggles every 2 clk, so one rising edge per 4 clk.
  bit tick_run = 1'b1;
  initial begin
    int div = 0;
    forever begin
      @(posedge clk); #2;
      if (tick_run) begin
        div++;
        if (div == 2) begin div = 0; tick_src = ~tick_src; end
      end
    end
  end

  typedef struct packed { logic dc; logic [DATA_W-1:0] data; } frame_t;
  frame_t exp_q[$];
  logic [DATA_W-1:0] bits;
  int nbits = 0, frame_ticks = 0, gap_ticks = 0, accepts = 0, dones = 0, sends = 0;
  bit gap_active = 0, exact_gap = 0;

  // Monitor, sampling at negedge: what it sees is what the DUT sees on the next posedge.
  initial begin
    logic p_tick = 0, p_sck = 0, p_mosi = 0, p_dc = 0, p_ready = 1, p_cs = 1;
    bit p_acc = 0, p_tk = 0, skip = 1, acc, tk;
    frame_t f;
    forever begin
      @(negedge clk);
      tk = tick_src & ~p_tick;
      acc = 0;
      if (!rst) begin
        exp_q.delete();
        nbits = 0;
        gap_active = 0;
        skip = 1;
      end else begin
        if (!skip) begin
          if (spi_sck !== p_sck) check("sck_on_tick", p_tk, 1);
          if (spi_mosi !== p_mosi) check("mosi_edge", p_acc | (p_sck & ~spi_sck), 1);
          if (spi_dc !== p_dc) check("dc_at_accept", p_acc, 1);
          if (spi_cs_n !== p_cs && !spi_cs_n) check("cs_fall_at_accept", p_acc, 1);
        end
        if (spi_sck && !p_sck && !spi_cs_n) begin
          bits = {bits[DATA_W-2:0], spi_mosi};
          nbits++;
        end
        if (tk && gap_active && spi_cs_n) gap_ticks++;
        if (done) begin
          dones++;
          if (exp_q.size() == 0) check("done_expected", 0, 1);
          else begin
            f = exp_q.pop_front();
            check("frame_data", bits, f.data);
            check("frame_bits", nbits, DATA_W);
            check("frame_dc", spi_dc, f.dc);
            check("done_tick", frame_ticks, 2 * DATA_W);
            check("done_cs", spi_cs_n, 1);
          end
          nbits = 0;
          gap_active = 1;
          gap_ticks = 0;
        end
        if (in_ready && !p_ready && !skip) check("ready_tick", frame_ticks, 2 * DATA_W + IDLE_TICKS);
        acc = in_valid & in_ready;
        if (acc) begin
          accepts++;
          exp_q.push_back('{dc: in_dc, data: in_data});
          frame_ticks = 0;
          nbits = 0;
          if (gap_active) begin
            if (exact_gap) check("gap_exact", gap_ticks, IDLE_TICKS);
            else check("gap_min", gap_ticks >= IDLE_TICKS, 1);
            gap_active = 0;
          end
        end else if (tk) frame_ticks++;
        skip = 0;
      end
      p_tick = tick_src; p_sck = spi_sck; p_mosi = spi_mosi; p_dc = spi_dc;
      p_ready = in_ready; p_cs = spi_cs_n; p_acc = acc; p_tk = tk;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic dc, input logic [DATA_W-1:0] d, input bit hold);
    int b = 0;
    in_valid = 1; in_dc = dc; in_data = d;
    while (!in_ready && b < 400) begin step(); b++; end
    if (b >= 400) check("send_timeout", 0, 1);
    sends++;
    step();
    check("ready_fall", in_ready, 0);
    check("cs_fall", spi_cs_n, 0);
    check("mosi_first", spi_mosi, d[DATA_W-1]);
    check("dc_load", spi_dc, dc);
    if (!hold) in_valid = 0;
  endtask

  // Garbage on the input side while busy must not reach the wire.
  task automatic noise_until_idle();
    int b = 0;
    while (!in_ready && b < 400) begin
      in_valid = 1'($urandom); in_dc = 1'($urandom); in_data = DATA_W'($urandom);
      step(); b++;
    end
    in_valid = 0;
    if (b >= 400) check("noise_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    int b = 0;
    while (!(in_ready && exp_q.size() == 0) && b < 1000) begin step(); b++; end
    if (b >= 1000) check("idle_timeout", 0, 1);
  endtask

  task automatic wait_bits(input int n);
    int b = 0;
    while (nbits < n && b < 200) begin step(); b++; end
    if (b >= 200) check("bits_timeout", 0, 1);
  endtask

  initial begin
    logic s_sck, s_mosi, s_cs;
    int changes, b;
    rst = 0;
    repeat (6) begin
      step();
      check("rst_cs", spi_cs_n, 1); check("rst_sck", spi_sck, 0);
      check("rst_ready", in_ready, 1); check("rst_done", done, 0);
      check("rst_mosi", spi_mosi, 0); check("rst_dc", spi_dc, 0);
    end
    rst = 1;
    step();

    send(0, 8'h2A, 0);
    wait_idle();

    exact_gap = 1;
    send(1, 8'h3C, 1);
    send(0, 8'hA5, 0);
    exact_gap = 0;
    wait_idle();

    send(1, 8'h96, 0);
    noise_until_idle();
    wait_idle();

    // Abandon a frame mid-flight.
    send(1, 8'hFF, 0);
    wait_bits(3);
    rst = 0;
    step();
    check("mid_rst_cs", spi_cs_n, 1); check("mid_rst_sck", spi_sck, 0);
    check("mid_rst_ready", in_ready, 1); check("mid_rst_done", done, 0);
    check("mid_rst_dc", spi_dc, 0);
    rst = 1;
    step();
    send(0, 8'h81, 0);
    wait_idle();

    // Freeze the tick source high mid-frame.
    send(0, 8'hC3, 0);
    wait_bits(3);
    b = 0;
    while (!tick_src && b < 20) begin step(); b++; end
    tick_run = 0;
    s_sck = spi_sck; s_mosi = spi_mosi; s_cs = spi_cs_n;
    changes = 0;
    repeat (50) begin
      step();
      if (spi_sck !== s_sck || spi_mosi !== s_mosi || spi_cs_n !== s_cs || done) changes++;
    end
    check("stall_frozen", changes, 0);
    tick_run = 1;
    wait_idle();

    repeat (14) begin
      bit hold;
      hold = 1'($urandom);
      send(1'($urandom), DATA_W'($urandom), hold);
      if (!hold) noise_until_idle();
      repeat ($urandom_range(0, 5)) step();
    end
    in_valid = 0;
    wait_idle();
    repeat (4) step();

    check("accept_count", accepts, sends);
    check("done_count", dones, sends - 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
